ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//   Initiator for the single-port 1024x20 program/data RAM. Accepts load, store and fill
//   requests from the CPU over a valid/ready handshake and drives the RAM control pins.
//   The RAM control pins are addr, write, str and ld. RAM read data is combinational
//   while ld is high, and RAM writes commit on posedge clk while str is high.
//   Sits between the CPU load/store path and the RAM; also clears or initialises memory ranges.
// PARAMETERS
//   ADDR_W  10  RAM address width; depth is 2**ADDR_W, all address arithmetic is modulo 2**ADDR_W
//   DATA_W  20  RAM word width
// PORTS
//   clk        in   1       single clock, all state updates on posedge
//   rst_n      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       controller can accept; handshake when req_valid && req_ready
//   req_op     in   2       00 load, 01 store, 10 fill, 11 reserved
//   req_addr   in   ADDR_W  target address (start address for fill)
//   req_len    in   ADDR_W  fill word count; 0 = no writes
//   req_wdata  in   DATA_W  store data / fill pattern
//   rsp_valid  out  1       one-cycle completion pulse
//   rsp_data   out  DATA_W  load result; 0 for other ops
//   rsp_err    out  1       high with rsp_valid for reserved op
//   busy       out  1       high in every state except IDLE
//   ram_addr   out  ADDR_W  to RAM addr
//   ram_write  out  DATA_W  to RAM write
//   ram_str    out  1       to RAM str
//   ram_ld     out  1       to RAM ld
//   ram_read   in   DATA_W  from RAM read; valid only while ram_ld=1
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE.
//     All outputs are 0 except req_ready=1.
//     Any in-flight fill is abandoned; no str pulse is issued after reset asserts.
//   States: IDLE, LOAD, STORE, FILL, DONE.
//   IDLE: req_ready=1, ram_str=0, ram_ld=0, ram_addr=0, ram_write=0.
//     On handshake, latch op/addr/len/wdata and go to the op state:
//     - 00 -> LOAD
//     - 01 -> STORE
//     - 10 with len!=0 -> FILL
//     - 10 with len==0 -> DONE
//     - 11 -> DONE with err flag set
//   LOAD: exactly 1 cycle.
//     Drives ram_ld=1 and ram_addr=latched addr.
//     Captures ram_read into rsp_data at the closing edge, then goes to DONE.
//   STORE: exactly 1 cycle.
//     Drives ram_str=1, ram_addr=addr, ram_write=wdata. The RAM commits at the closing edge.
//     Then goes to DONE.
//   FILL: one word per cycle with ram_str=1 and ram_write=pattern.
//     ram_addr starts at addr and increments each cycle, wrapping 1023->0.
//     A down-counter loaded with len reaches 0 after len writes, then the state goes to DONE.
//   DONE: exactly 1 cycle. rsp_valid=1 and req_ready=0; rsp_err=1 only for op 11.
//     rsp_data is held valid this cycle; returns to IDLE.
//   Latency: load/store handshake at edge N -> rsp_valid in cycle N+2 (data is ready then).
//     Fill of length L -> rsp_valid in cycle N+1+L.
//   Throughput: at most one request every 3 cycles for load/store.
//     req_ready=0 in all non-IDLE states; inputs are ignored while busy.
//   ram_ld and ram_str are never high in the same cycle. ram_ld is high only in LOAD.
//   rsp_data is cleared to 0 on entry to DONE for non-load ops.
// TESTING
//   1. Reset: pulse rst_n low mid-cycle -> outputs clear immediately.
//      req_ready=1, busy=0, ram_str=0, ram_ld=0.
//   2. Store 0xABCDE @ 0x005, then load @ 0x005.
//      -> ram_str high for 1 cycle with ram_addr=0x005.
//      -> load rsp_valid at N+2 with rsp_data=0xABCDE, rsp_err=0.
//   3. Fill addr=0x3FE, len=4, wdata=0x12345 -> writes to 0x3FE, 0x3FF, 0x000, 0x001.
//      -> exactly 4 str cycles; loads of those addresses return 0x12345; 0x002 is unchanged.
//   4. Fill len=0 -> no ram_str pulse; rsp_valid 1 cycle after handshake.
//      Op 11 -> rsp_valid with rsp_err=1 and no RAM activity.
//   5. Assert rst_n=0 during cycle 3 of a len=10 fill.
//      -> str drops at once; exactly 2 committed writes; controller returns to IDLE.
//   6. Hold req_valid high with changing ops while busy -> none are accepted until DONE->IDLE.
//      Back-to-back loads complete every 3 cycles.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Request-driven initiator for the single-port program/data RAM: performs single-word
// loads/stores and multi-word pattern fills, reporting completion with a one-cycle pulse.
module ram_access_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write,
    output logic              ram_str,
    output logic              ram_ld,
    input  logic [DATA_W-1:0] ram_read
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               err_q;
    logic               hs;

    assign hs = req_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        ram_addr  = '0;
        ram_write = '0;
        ram_str   = 1'b0;
        ram_ld    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    case (req_op)
                        OP_LOAD:  state_d = LOAD;
                        OP_STORE: state_d = STORE;
                        OP_FILL:  state_d = (req_len != '0) ? FILL : DONE;
                        default:  state_d = DONE;
                    endcase
                end
            end
            LOAD: begin
                ram_ld   = 1'b1;
                ram_addr = addr_q;
                state_d  = DONE;
            end
            STORE: begin
                ram_str   = 1'b1;
                ram_addr  = addr_q;
                ram_write = wdata_q;
                state_d   = DONE;
            end
            FILL: begin
                ram_str   = 1'b1;
                ram_addr  = addr_q;
                ram_write = wdata_q;
                // cnt_q counts words still to write, including this cycle's
                if (cnt_q == ADDR_W'(1)) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (hs) begin
                addr_q  <= req_addr;
                cnt_q   <= req_len;
                wdata_q <= req_wdata;
                err_q   <= (req_op == 2'b11);
            end
            if (state_q == LOAD) begin
                rsp_data_q <= ram_read;
            end else if (state_d == DONE && state_q != DONE) begin
                rsp_data_q <= '0;
            end
            // Address wraps naturally at 2**ADDR_W
            if (state_q == FILL) begin
                addr_q <= addr_q + ADDR_W'(1);
                cnt_q  <= cnt_q - ADDR_W'(1);
            end
        end
    end

    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboarded bench for ram_access_ctrl with a behavioural 1024x20 RAM attached.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [9:0]  req_addr;
    logic [9:0]  req_len;
    logic [19:0] req_wdata;
    logic        rsp_valid;
    logic [19:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [9:0]  ram_addr;
    logic [19:0] ram_write;
    logic        ram_str;
    logic        ram_ld;
    logic [19:0] ram_read;

    ram_access_ctrl #(.ADDR_W(10), .DATA_W(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_str(ram_str), .ram_ld(ram_ld),
        .ram_read(ram_read)
    );

    always #5 clk = ~clk;

    // RAM model; 2-state storage starts at zero
    bit [19:0] mem [1024];
    always @(posedge clk) if (ram_str) mem[ram_addr] <= ram_write;
    assign ram_read = ram_ld ? mem[ram_addr] : 20'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int str_cnt = 0;
    int ld_cnt  = 0;
    logic [9:0]  last_str_addr;
    logic [19:0] last_str_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", {12'h0, rsp_data}, {12'h0, e.data});
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
            if (ram_str) begin
                str_cnt++;
                last_str_addr = ram_addr;
                last_str_data = ram_write;
            end
            if (ram_ld) ld_cnt++;
            if (ram_ld || ram_str) check("ld_str_excl", {31'h0, ram_ld & ram_str}, 32'd0);
        end
    end

    // lat is the documented handshake-to-rsp_valid latency in cycles
    task automatic issue(input logic [1:0] op, input logic [9:0] addr, input logic [9:0] len,
                         input logic [19:0] wdata, input logic [19:0] edata, input logic eerr,
                         input int lat);
        int n;
        exp_t e;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_len = len; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check("issue_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        e.data = edata; e.err = eerr; e.cyc = cyc + lat - 1;
        exp_q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (busy || exp_q.size() != 0) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, l0, k, last_hs, hs;
        bit took;
        logic [9:0]  addrs [4];
        logic [19:0] edat  [4];
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_addr = '0; req_len = '0; req_wdata = '0;

        // 1. reset state
        #2;
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_busy",  {31'h0, busy},      32'd0);
        check("rst_str",   {31'h0, ram_str},   32'd0);
        check("rst_ld",    {31'h0, ram_ld},    32'd0);
        check("rst_rspv",  {31'h0, rsp_valid}, 32'd0);
        check("rst_rspd",  {12'h0, rsp_data},  32'd0);
        check("rst_addr",  {22'h0, ram_addr},  32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 2. store then load
        s0 = str_cnt;
        issue(2'b01, 10'h005, 10'h0, 20'hABCDE, 20'h0, 1'b0, 2);
        wait_idle();
        check("st_cnt",  str_cnt - s0, 32'd1);
        check("st_addr", {22'h0, last_str_addr}, 32'h005);
        check("st_data", {12'h0, last_str_data}, 32'hABCDE);
        issue(2'b00, 10'h005, 10'h0, 20'h0, 20'hABCDE, 1'b0, 2);
        wait_idle();

        // 3. wrapping fill
        issue(2'b01, 10'h002, 10'h0, 20'h00777, 20'h0, 1'b0, 2);
        wait_idle();
        s0 = str_cnt;
        issue(2'b10, 10'h3FE, 10'd4, 20'h12345, 20'h0, 1'b0, 5);
        wait_idle();
        check("fill_cnt",  str_cnt - s0, 32'd4);
        check("fill_last", {22'h0, last_str_addr}, 32'h001);
        issue(2'b00, 10'h3FE, 10'h0, 20'h0, 20'h12345, 1'b0, 2); wait_idle();
        issue(2'b00, 10'h3FF, 10'h0, 20'h0, 20'h12345, 1'b0, 2); wait_idle();
        issue(2'b00, 10'h000, 10'h0, 20'h0, 20'h12345, 1'b0, 2); wait_idle();
        issue(2'b00, 10'h001, 10'h0, 20'h0, 20'h12345, 1'b0, 2); wait_idle();
        issue(2'b00, 10'h002, 10'h0, 20'h0, 20'h00777, 1'b0, 2); wait_idle();

        // 4. zero-length fill and reserved op
        s0 = str_cnt; l0 = ld_cnt;
        issue(2'b10, 10'h010, 10'd0, 20'hFFFFF, 20'h0, 1'b0, 1); wait_idle();
        issue(2'b11, 10'h020, 10'd3, 20'h11111, 20'h0, 1'b1, 1); wait_idle();
        check("z_str", str_cnt - s0, 32'd0);
        check("z_ld",  ld_cnt - l0,  32'd0);

        // 5. reset during the third cycle of a 10-word fill
        s0 = str_cnt;
        issue(2'b10, 10'h100, 10'd10, 20'h55555, 20'h0, 1'b0, 11);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("ab_str",   {31'h0, ram_str},   32'd0);
        check("ab_busy",  {31'h0, busy},      32'd0);
        check("ab_ready", {31'h0, req_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ab_cnt",  str_cnt - s0, 32'd2);
        check("ab_m100", {12'h0, mem[10'h100]}, 32'h55555);
        check("ab_m101", {12'h0, mem[10'h101]}, 32'h55555);
        check("ab_m102", {12'h0, mem[10'h102]}, 32'h0);
        repeat (3) @(posedge clk);
        #1 check("ab_idle", {31'h0, busy}, 32'd0);

        // 6. continuous req_valid with noise ops while busy
        addrs[0] = 10'h005; edat[0] = 20'hABCDE;
        addrs[1] = 10'h3FE; edat[1] = 20'h12345;
        addrs[2] = 10'h002; edat[2] = 20'h00777;
        addrs[3] = 10'h3FF; edat[3] = 20'h12345;
        s0 = str_cnt; k = 0; last_hs = 0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            req_valid = 1'b1;
            if (req_ready) begin
                req_op = 2'b00; req_addr = addrs[k]; took = 1'b1;
            end else begin
                req_op = 2'($urandom_range(1, 3)); req_addr = 10'h005;
                req_len = 10'd3; req_wdata = 20'($urandom); took = 1'b0;
            end
            @(posedge clk); #1;
            if (took) begin
                exp_t e;
                hs = cyc;
                e.data = edat[k]; e.err = 1'b0; e.cyc = hs + 1;
                exp_q.push_back(e);
                if (k > 0) check("b2b_gap", hs - last_hs, 32'd3);
                last_hs = hs;
                k++;
            end
        end
        req_valid = 1'b0;
        check("b2b_count", k, 32'd4);
        wait_idle();
        check("b2b_nostr", str_cnt - s0, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
